// File: rtl/sistema_datapath_if.sv
// sistema_datapath_if: groups the operand/enable inputs and the display/LED
// outputs of the teaching datapath so board glue and benches connect in one go.
interface sistema_datapath_if;
  logic [3:0] data;
  logic       selectMux;
  logic       ena;
  logic       enb;
  logic       enc;
  logic       enshift;
  logic [6:0] out0;
  logic [6:0] out1;
  logic [6:0] out2;
  logic [6:0] out3;
  logic [6:0] out4;
  logic [6:0] out5;
  logic [2:0] outled1;
  logic [1:0] outled2;

  modport master (
    output data, selectMux, ena, enb, enc, enshift,
    input  out0, out1, out2, out3, out4, out5, outled1, outled2
  );

  modport slave (
    input  data, selectMux, ena, enb, enc, enshift,
    output out0, out1, out2, out3, out4, out5, outled1, outled2
  );
endinterface

// File: rtl/sistema_datapath.sv
// sistema_datapath: 4-bit teaching datapath. Register A captures the switches,
// B pipelines A, an add/sub ALU feeds result register C plus flag LEDs, and a
// three-stage shift chain records past results. All six registers are shown
// as hex digits on 7-segment displays.
// Optional macro SEG_ACTIVE_HIGH_EN: when defined, the segment outputs are
// inverted for common-cathode (active-high) boards; LEDs are unaffected.
module sistema_datapath #(
  parameter logic [3:0] SHIFT_RST_VAL = 4'h0
) (
  input logic               clk,
  input logic               rst,
  sistema_datapath_if.slave bus
);

  logic [3:0] rega;
  logic [3:0] regb;
  logic [3:0] regc;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [2:0] flags;
  logic [1:0] fillcnt;
  logic [4:0] r5;

  // Hex digit to segment pattern {g,f,e,d,c,b,a}, active-low unless inverted.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
`ifdef SEG_ACTIVE_HIGH_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  // ALU on the registered operands; the 5th bit is carry for add and borrow
  // for subtract, since A-B in 5 bits goes negative exactly when A < B.
  always_comb begin
    r5 = {1'b0, rega} + {1'b0, regb};
    if (bus.selectMux) begin
      r5 = {1'b0, rega} - {1'b0, regb};
    end
  end

  // All state updates from pre-edge values; reset overrides every enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rega    <= 4'h0;
      regb    <= 4'h0;
      regc    <= 4'h0;
      flags   <= 3'b000;
      s0      <= SHIFT_RST_VAL;
      s1      <= SHIFT_RST_VAL;
      s2      <= SHIFT_RST_VAL;
      fillcnt <= 2'd0;
    end else begin
      if (bus.ena) begin
        rega <= bus.data;
      end
      if (bus.enb) begin
        regb <= rega;
      end
      if (bus.enc) begin
        regc  <= r5[3:0];
        flags <= {r5[4], (r5[3:0] == 4'h0), r5[3]};
      end
      if (bus.enshift) begin
        s2 <= s1;
        s1 <= s0;
        s0 <= regc;
        if (fillcnt != 2'd3) begin
          fillcnt <= fillcnt + 2'd1;
        end
      end
    end
  end

  // Display and LED drive straight from the registers.
  always_comb begin
    bus.out0    = seg7(rega);
    bus.out1    = seg7(regb);
    bus.out2    = seg7(regc);
    bus.out3    = seg7(s0);
    bus.out4    = seg7(s1);
    bus.out5    = seg7(s2);
    bus.outled1 = flags;
    bus.outled2 = fillcnt;
  end

endmodule

// File: tb/tb_sistema_datapath.sv
// tb_sistema_datapath: directed vector table following the datapath's worked
// examples, a hand-written mid-cycle reset sequence, and randomized traffic
// compared against an arithmetic reference model of the datapath.
module tb_sistema_datapath;

  localparam logic [3:0] SHIFT_RST = 4'h0;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  // Reference model state, kept as plain integers.
  int ma, mb, mc, mLed1, mCnt;
  int mShift[3];

  int segTable[16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                       7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                       7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    logic       rst;
    logic [3:0] data;
    logic       sel;
    logic       ena;
    logic       enb;
    logic       enc;
    logic       ensh;
    int         eA;
    int         eB;
    int         eC;
    int         eS0;
    int         eS1;
    int         eS2;
    int         eLed1;
    int         eLed2;
  } vec_t;

  vec_t vecs[$];

  sistema_datapath_if bus ();

  sistema_datapath #(.SHIFT_RST_VAL(SHIFT_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int expSeg(input int v);
`ifdef SEG_ACTIVE_HIGH_EN
    return (~segTable[v & 15]) & 8'h7f;
`else
    return segTable[v & 15];
`endif
  endfunction

  function automatic vec_t mkVec(input logic r, input logic [3:0] d, input logic s,
                                 input logic a, input logic b, input logic c,
                                 input logic sh, input int xa, input int xb,
                                 input int xc, input int x0, input int x1,
                                 input int x2, input int l1, input int l2);
    vec_t v;
    v.rst = r; v.data = d; v.sel = s; v.ena = a; v.enb = b; v.enc = c; v.ensh = sh;
    v.eA = xa; v.eB = xb; v.eC = xc; v.eS0 = x0; v.eS1 = x1; v.eS2 = x2;
    v.eLed1 = l1; v.eLed2 = l2;
    return v;
  endfunction

  // Advance the reference model by one clock edge using the datapath rules.
  task automatic modelStep(input logic r, input int d, input logic s, input logic a,
                           input logic b, input logic c, input logic sh);
    int res, diff, nextC, nextS0;
    bit cb;
    if (!r) begin
      ma = 0; mb = 0; mc = 0; mLed1 = 0; mCnt = 0;
      for (int i = 0; i < 3; i++) mShift[i] = SHIFT_RST;
      return;
    end
    if (s) begin
      diff = ma - mb;
      cb = (ma < mb);
    end else begin
      diff = ma + mb;
      cb = (diff > 15);
    end
    res = ((diff % 16) + 16) % 16;
    nextC = mc;
    nextS0 = mc;
    if (c) begin
      nextC = res;
      mLed1 = (cb ? 4 : 0) + ((res == 0) ? 2 : 0) + ((res >= 8) ? 1 : 0);
    end
    if (sh) begin
      mShift[2] = mShift[1];
      mShift[1] = mShift[0];
      mShift[0] = nextS0;
      if (mCnt < 3) mCnt = mCnt + 1;
    end
    if (b) mb = ma;
    if (a) ma = d;
    mc = nextC;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input int xa, input int xb, input int xc,
                            input int x0, input int x1, input int x2,
                            input int l1, input int l2);
    checkOutput({tag, ".out0"}, int'(bus.out0), expSeg(xa));
    checkOutput({tag, ".out1"}, int'(bus.out1), expSeg(xb));
    checkOutput({tag, ".out2"}, int'(bus.out2), expSeg(xc));
    checkOutput({tag, ".out3"}, int'(bus.out3), expSeg(x0));
    checkOutput({tag, ".out4"}, int'(bus.out4), expSeg(x1));
    checkOutput({tag, ".out5"}, int'(bus.out5), expSeg(x2));
    checkOutput({tag, ".outled1"}, int'(bus.outled1), l1);
    checkOutput({tag, ".outled2"}, int'(bus.outled2), l2);
  endtask

  task automatic checkModel(input string tag);
    checkState(tag, ma, mb, mc, mShift[0], mShift[1], mShift[2], mLed1, mCnt);
  endtask

  // Drive inputs on the falling edge, take the rising edge, settle 1 time unit.
  task automatic applyStimulus(input logic r, input logic [3:0] d, input logic s,
                               input logic a, input logic b, input logic c,
                               input logic sh);
    @(negedge clk);
    rst = r;
    bus.data = d;
    bus.selectMux = s;
    bus.ena = a;
    bus.enb = b;
    bus.enc = c;
    bus.enshift = sh;
    @(posedge clk);
    modelStep(r, int'(d), s, a, b, c, sh);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    checkCount = 0;
    passCount = 0;
    rst = 1'b0;
    bus.data = 4'h0;
    bus.selectMux = 1'b0;
    bus.ena = 1'b0;
    bus.enb = 1'b0;
    bus.enc = 1'b0;
    bus.enshift = 1'b0;
    ma = 0; mb = 0; mc = 0; mLed1 = 0; mCnt = 0;
    for (int i = 0; i < 3; i++) mShift[i] = SHIFT_RST;

    //                r  data  s  a  b  c  sh   A  B  C S0 S1 S2 led1 led2
    vecs.push_back(mkVec(0, 4'h5, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 4'h5, 1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 4'h1, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 4'h1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 0,  1, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 4'hF, 0, 1, 0, 0, 0, 15, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 0, 15, 1, 0, 0, 0, 0, 6, 0));
    vecs.push_back(mkVec(1, 4'h1, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 6, 0));
    vecs.push_back(mkVec(1, 4'h0, 1, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mkVec(1, 4'h0, 1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mkVec(1, 4'h0, 1, 0, 0, 1, 0,  0, 1, 15, 0, 0, 0, 5, 0));
    vecs.push_back(mkVec(1, 4'h1, 0, 1, 0, 0, 0,  1, 1, 15, 0, 0, 0, 5, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 0,  1, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 1,  1, 1, 2, 2, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 1,  1, 1, 2, 2, 2, 0, 0, 2));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 1,  1, 1, 2, 2, 2, 2, 0, 3));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 1,  1, 1, 2, 2, 2, 2, 0, 3));
    vecs.push_back(mkVec(0, 4'h7, 1, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] directed vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].data, vecs[i].sel, vecs[i].ena,
                    vecs[i].enb, vecs[i].enc, vecs[i].ensh);
      checkState($sformatf("vec%0d", i), vecs[i].eA, vecs[i].eB, vecs[i].eC,
                 vecs[i].eS0, vecs[i].eS1, vecs[i].eS2, vecs[i].eLed1, vecs[i].eLed2);
    end

    $display("[TB] reset asserted between edges");
    applyStimulus(1, 4'h9, 0, 1, 1, 0, 0);
    applyStimulus(1, 4'h6, 0, 1, 1, 1, 1);
    checkModel("midrun.before");
    rst = 1'b0;
    #2;
    checkModel("midrun.between");
    @(posedge clk);
    modelStep(1'b0, int'(bus.data), bus.selectMux, bus.ena, bus.enb, bus.enc, bus.enshift);
    #1;
    checkState("midrun.after", 0, 0, 0, SHIFT_RST, SHIFT_RST, SHIFT_RST, 0, 0);

    $display("[TB] randomized traffic against reference model");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 24) != 0), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      checkModel($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
